// File: rtl/alu_op_sequencer_if.sv
// Command/response, regfile and ALU bundle for alu_op_sequencer.
// Optional op_count exists only when ALU_SEQ_STATS_EN is defined.
interface alu_op_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 3
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] rsp_rd;
  logic              busy;
`ifdef ALU_SEQ_STATS_EN
  logic [31:0]       op_count;
`endif

  // Environment side: issuer, regfile, ALU and response consumer
  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    output rf_rdata1, rf_rdata2, alu_y, rsp_ready,
    input  cmd_ready, rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata,
    input  alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_rd, busy
`ifdef ALU_SEQ_STATS_EN
    , input op_count
`endif
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
    input  rf_rdata1, rf_rdata2, alu_y, rsp_ready,
    output cmd_ready, rf_rs1, rf_rs2, rf_we, rf_rd, rf_wdata,
    output alu_a, alu_b, alu_op, rsp_valid, rsp_data, rsp_rd, busy
`ifdef ALU_SEQ_STATS_EN
    , output op_count
`endif
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle read/execute/writeback sequencer owning the regfile ports and ALU.
// Define ALU_SEQ_STATS_EN to add a saturating response-handshake counter (op_count).
module alu_op_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned OP_W   = 3
) (
  input logic             clk,
  input logic             rst,
  alu_op_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RSP  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_cmd_fire;
  logic              w_rsp_fire;

  logic              r_cmd_ready;
  logic              r_busy;
  logic              r_rf_we;
  logic              r_rsp_valid;

  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [OP_W-1:0]   r_alu_op;
  logic [DATA_W-1:0] r_result;

  // Next-state decode
  always_comb begin
    w_next     = r_state;
    w_cmd_fire = 1'b0;
    w_rsp_fire = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_fire = 1'b1;
          w_next     = S_READ;
        end
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WB;
      S_WB:   w_next = S_RSP;
      S_RSP: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_rsp_fire = 1'b1;
          w_next     = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State and control flags, registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= (w_next == S_IDLE);
      r_busy      <= (w_next != S_IDLE);
      r_rf_we     <= (w_next == S_WB) && (r_rd != '0);
      r_rsp_valid <= (w_next == S_RSP);
    end
  end

  // Command capture, operand fetch and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_alu_op <= '0;
      r_result <= '0;
    end else begin
      if (w_cmd_fire) begin
        r_op  <= bus.cmd_op;
        r_rd  <= bus.cmd_rd;
        r_rs1 <= bus.cmd_rs1;
        r_rs2 <= bus.cmd_rs2;
      end
      if (r_state == S_READ) begin
        r_opa    <= bus.rf_rdata1;
        r_opb    <= bus.rf_rdata2;
        r_alu_op <= r_op;
      end
      if (r_state == S_EXEC) begin
        r_result <= bus.alu_y;
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_rsp_fire && (r_op_count != 32'hFFFF_FFFF)) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign bus.op_count = r_op_count;
`else
  logic w_unused_rsp_fire;
  assign w_unused_rsp_fire = w_rsp_fire;
`endif

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.rf_rs1    = r_rs1;
  assign bus.rf_rs2    = r_rs2;
  // Reset in the WB cycle must suppress that edge's write
  assign bus.rf_we     = r_rf_we & ~rst;
  assign bus.rf_rd     = r_rd;
  assign bus.rf_wdata  = r_result;
  assign bus.alu_a     = r_opa;
  assign bus.alu_b     = r_opb;
  assign bus.alu_op    = r_alu_op;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_result;
  assign bus.rsp_rd    = r_rd;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural regfile and ALU.
module tb_alu_op_sequencer;
  logic clk;
  logic rst;

  alu_op_sequencer_if #(.DATA_W(32), .ADDR_W(5), .OP_W(3)) bus ();

  alu_op_sequencer #(.DATA_W(32), .ADDR_W(5), .OP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_rsp[$];
  exp_t exp_wr[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Regfile model: combinational read, x0 hard-wired to zero
  logic [31:0] rf [32];
  logic        tb_clr;
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end else if (bus.rf_we && (bus.rf_rd != 5'd0)) begin
      rf[bus.rf_rd] <= bus.rf_wdata;
    end
  end

  assign bus.rf_rdata1 = (bus.rf_rs1 == 5'd0) ? 32'd0 : rf[bus.rf_rs1];
  assign bus.rf_rdata2 = (bus.rf_rs2 == 5'd0) ? 32'd0 : rf[bus.rf_rs2];

  always_comb begin
    case (bus.alu_op)
      3'd0:    bus.alu_y = bus.alu_a + bus.alu_b;
      3'd1:    bus.alu_y = bus.alu_a - bus.alu_b;
      3'd2:    bus.alu_y = bus.alu_a & bus.alu_b;
      3'd3:    bus.alu_y = bus.alu_a | bus.alu_b;
      3'd4:    bus.alu_y = bus.alu_a ^ bus.alu_b;
      default: bus.alu_y = bus.alu_a;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_rsp.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_rd", 32'(bus.rsp_rd), 32'(e.rd));
      end
    end
  end

  // Regfile write monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rf_we) begin
      if (exp_wr.size() == 0) begin
        chk("wr_unexpected", 32'(bus.rf_rd), 32'hFFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_data", bus.rf_wdata, e.data);
        chk("wr_rd", 32'(bus.rf_rd), 32'(e.rd));
      end
    end
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Returns 1 ns into the cycle after acceptance (READ)
  task automatic send_cmd(input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
    logic rdy;
    int   n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_rs1   = rs1;
    bus.cmd_rs2   = rs2;
    forever begin
      @(negedge clk);
      rdy = bus.cmd_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        chk("cmd_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      n++;
      if (n > 50) begin
        chk("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tb_clr = 1'b1;
    pl_en = 1'b0;
    pl_addr = 5'd0;
    pl_data = 32'd0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = 3'd0;
    bus.cmd_rd = 5'd3;
    bus.cmd_rs1 = 5'd1;
    bus.cmd_rs2 = 5'd2;
    bus.rsp_ready = 1'b0;

    // Reset held two cycles with a command offered
    repeat (2) begin
      @(negedge clk);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_rf_rs1", 32'(bus.rf_rs1), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tb_clr = 1'b0;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;

    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    bus.rsp_ready = 1'b1;

    // Basic add x3 = x1 + x2 with cycle-exact checks
    exp_rsp.push_back('{data: 32'd8, rd: 5'd3});
    exp_wr.push_back('{data: 32'd8, rd: 5'd3});
    send_cmd(3'd0, 5'd3, 5'd1, 5'd2);
    @(negedge clk);
    chk("t1_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("t1_rf_rs1", 32'(bus.rf_rs1), 32'd1);
    chk("t1_rf_rs2", 32'(bus.rf_rs2), 32'd2);
    @(negedge clk);
    chk("t2_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t2_alu_a", bus.alu_a, 32'd5);
    chk("t2_alu_b", bus.alu_b, 32'd3);
    chk("t2_alu_op", 32'(bus.alu_op), 32'd0);
    @(negedge clk);
    chk("t3_rf_we", 32'(bus.rf_we), 32'd1);
    chk("t3_rf_rd", 32'(bus.rf_rd), 32'd3);
    chk("t3_rf_wdata", bus.rf_wdata, 32'd8);
    chk("t3_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("t4_rf_we", 32'(bus.rf_we), 32'd0);
    chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rf_x3", rf[3], 32'd8);
    @(posedge clk); #1;

    // x0 destination: response only, no write
    exp_rsp.push_back('{data: 32'd8, rd: 5'd0});
    send_cmd(3'd0, 5'd0, 5'd1, 5'd2);
    wait_idle();
    chk("x0_reads_zero", bus.rf_rdata1 & 32'd0 | ((5'd0 == 5'd0) ? rf[0] & 32'd0 : 32'd0) | 32'(rf[0] != 32'd0), 32'd0);

    // Backpressure: x6 = x1 - x2, with next command (x7 = x1 ^ x2) held valid
    bus.rsp_ready = 1'b0;
    exp_rsp.push_back('{data: 32'd2, rd: 5'd6});
    exp_wr.push_back('{data: 32'd2, rd: 5'd6});
    send_cmd(3'd1, 5'd6, 5'd1, 5'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'd4;
    bus.cmd_rd    = 5'd7;
    bus.cmd_rs1   = 5'd1;
    bus.cmd_rs2   = 5'd2;
    n = 0;
    forever begin
      @(negedge clk);
      chk("bp_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      if (bus.rsp_valid) break;
      n++;
      if (n > 20) begin
        chk("bp_rsp_timeout", 32'd0, 32'd1);
        break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.rsp_data, 32'd2);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    exp_rsp.push_back('{data: 32'd6, rd: 5'd7});
    exp_wr.push_back('{data: 32'd6, rd: 5'd7});
    @(negedge clk);
    chk("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp_idle_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_accepted", 32'(bus.busy), 32'd1);
    wait_idle();
    chk("rf_x7", rf[7], 32'd6);

    // Dependent back-to-back: x3 = x1 + x2, then x4 = x3 + x3
    preload(5'd3, 32'd0);
    exp_rsp.push_back('{data: 32'd8, rd: 5'd3});
    exp_wr.push_back('{data: 32'd8, rd: 5'd3});
    send_cmd(3'd0, 5'd3, 5'd1, 5'd2);
    exp_rsp.push_back('{data: 32'd16, rd: 5'd4});
    exp_wr.push_back('{data: 32'd16, rd: 5'd4});
    send_cmd(3'd0, 5'd4, 5'd3, 5'd3);
    wait_idle();
    chk("rf_x4", rf[4], 32'd16);
`ifdef ALU_SEQ_STATS_EN
    chk("op_count_6", bus.op_count, 32'd6);
`endif

    // Reset during WB of x5 = x1 + x2
    preload(5'd5, 32'd0);
    send_cmd(3'd0, 5'd5, 5'd1, 5'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rf_we", 32'(bus.rf_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    chk("op_count_rst", bus.op_count, 32'd0);
`endif
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    chk("rf_x5", rf[5], 32'd0);

    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that owns the register file read/write ports and the ALU.
- Accepts one register-to-register operation per command (op, rd, rs1, rs2) over a valid/ready handshake.
- Sequences the operation as: read operands, execute, write back. Then returns the result on a valid/ready response channel.
- Sits between the decode/issue logic and the regfile/ALU pair. It is the only driver of their control inputs.

Parameters:
- DATA_W, 32, datapath width (regfile data, ALU operands/result)
- ADDR_W, 5, register index width
- OP_W, 3, ALU op code width; passed through unmodified to the ALU

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  OP_W  ALU operation
- cmd_rd  in  ADDR_W  destination register
- cmd_rs1  in  ADDR_W  source register A
- cmd_rs2  in  ADDR_W  source register B
- rf_rs1  out  ADDR_W  regfile read address 1
- rf_rs2  out  ADDR_W  regfile read address 2
- rf_rdata1  in  DATA_W  regfile read data 1 (combinational read)
- rf_rdata2  in  DATA_W  regfile read data 2
- rf_we  out  1  regfile write enable
- rf_rd  out  ADDR_W  regfile write address
- rf_wdata  out  DATA_W  regfile write data
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_op  out  OP_W  ALU op code
- alu_y  in  DATA_W  ALU result (combinational)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  DATA_W  result value
- rsp_rd  out  ADDR_W  destination register of result
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, READ, EXEC, WB, RSP. State and all datapath registers are updated on the clk rising edge.
- Reset (rst=1 at an edge) returns to IDLE and clears every captured register to 0. An in-flight command is discarded and no response is produced.
- Output values while in reset and after it: cmd_ready=1, rsp_valid=0, rf_we=0, busy=0. All address, data and op outputs are 0.
- rf_we is gated with !rst. A reset asserted in a WB cycle therefore blocks the regfile write on that edge.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, capture op/rd/rs1/rs2 and go to READ. cmd_ready is 0 in all other states.
- READ (T+1): drive rf_rs1/rf_rs2 from the captured indices. At the end of the cycle, capture rf_rdata1/2 into the operand registers. Go to EXEC.
- EXEC (T+2): drive alu_a/alu_b from the operand registers and alu_op from the captured op. Capture alu_y into the result register. Go to WB.
- WB (T+3): rf_rd=captured rd, rf_wdata=result, rf_we=1 for exactly one cycle. Exception: if rd==0, rf_we stays 0 because x0 is never written. Go to RSP.
- RSP (T+4 onward): rsp_valid=1; rsp_data/rsp_rd are held stable until the handshake.
  - On rsp_valid&&rsp_ready, go to IDLE. rsp_valid deasserts the next cycle.
  - rsp_ready may be held high early; the earliest possible handshake is cycle T+4.
- Minimum throughput: one command per 5 cycles. A new command is accepted in the IDLE cycle that follows the response handshake.
- Hazard: the write in WB completes at least 2 edges before the next command's READ. Back-to-back dependent commands therefore see the updated value with no forwarding.
- Outside their active states, rf_rs*/alu_* hold their last driven value. Consumers must ignore them. rf_we is 0 outside WB.
- cmd_* inputs are ignored when cmd_ready=0.
- No arithmetic in the sequencer; results are the ALU's, width DATA_W, unchanged.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- When defined, adds output op_count (32 bits):
  - counts completed response handshakes
  - saturates at 0xFFFFFFFF
  - cleared by rst
- When undefined, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with cmd_valid=1 -> cmd_ready=1, busy=0, rsp_valid=0, rf_we=0; no command is accepted during reset.
- Basic add: preload x1=5, x2=3; issue op=000, rd=3, rs1=1, rs2=2 at T -> rf_we=1 only at T+3 with rf_rd=3, rf_wdata=8; rsp_valid rises at T+4 with rsp_data=8, rsp_rd=3.
- x0 destination: same operands with rd=0 -> rf_we never asserts; rsp_data=8, rsp_rd=0; x0 still reads 0.
- Backpressure: rsp_ready=0 for 10 cycles with cmd_valid=1 held -> rsp_valid stays 1 and rsp_data is stable; cmd_ready=0 throughout; the second command is accepted only after the handshake.
- Dependent back-to-back: x3=x1+x2, then x4=x3+x3 -> second response rsp_data=16; regfile x4=16.
- Reset mid-op: assert rst during the WB cycle of x5=x1+x2 (x5 initially 0) -> x5 remains 0, no response; next cycle cmd_ready=1, busy=0. With ALU_SEQ_STATS_EN defined, op_count=0.
